// File: rtl/gf_serial_multiplier.sv
// Digit-serial GF(2^WIDTH) multiplier, LSB-first, reduced modulo POLY.
// Define GF_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier is zero.
module gf_serial_multiplier #(
  parameter int unsigned           WIDTH = 8,
  parameter logic [WIDTH-1:0]      POLY  = 8'h1B,
  parameter int unsigned           DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             busy
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if ((DIGIT == 0) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("gf_serial_multiplier: DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a, b, acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb, sacc;
  logic             accept, finish;

  // One cycle's worth of shift-and-add steps
  always_comb begin
    sa   = a;
    sb   = b;
    sacc = acc;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (sb[0]) sacc = sacc ^ sa;
      sa = (sa << 1) ^ (sa[WIDTH-1] ? POLY : '0);
      sb = sb >> 1;
    end
  end

  assign accept = in_valid && (state == IDLE);

`ifdef GF_MUL_EARLY_TERM_EN
  assign finish = (cnt == LAST) || (sb == '0);
`else
  assign finish = (cnt == LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = CALC;
      CALC:    if (finish) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      cnt   <= '0;
      out_p <= '0;
    end else if (accept) begin
      a   <= in_a;
      b   <= in_b;
      acc <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      a   <= sa;
      b   <= sb;
      acc <= sacc;
      cnt <= cnt + 1'b1;
      if (finish) out_p <= sacc;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gf_serial_multiplier.sv
// Randomized self-checking bench for gf_serial_multiplier (default parameters).
// Reference: full carry-less product followed by polynomial long division.
module tb_gf_serial_multiplier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_p;
  logic       busy;

  int n_pass = 0;
  int n_tot  = 0;

  gf_serial_multiplier dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] gf_ref(input logic [7:0] x,
                                        input logic [7:0] y);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++)
      if (y[i]) p ^= 16'(x) << i;
    for (int i = 15; i >= 8; i--)
      if (p[i]) p ^= 16'h11B << (i - 8);
    return p[7:0];
  endfunction

  function automatic int exp_lat(input logic [7:0] y);
`ifdef GF_MUL_EARLY_TERM_EN
    int m = 0;
    for (int i = 0; i < 8; i++) if (y[i]) m = i;
    return m + 1;
`else
    return 8;
`endif
  endfunction

  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        input int hold, input string tag);
    logic [7:0] want;
    int  lat;
    bit  busy_ok;
    want = gf_ref(x, y);
    @(negedge clk);
    in_a = x; in_b = y; in_valid = 1'b1;
    chk({tag, " in_ready"}, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 8'($urandom); in_b = 8'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat(y)));
    chk({tag, " busy"}, 32'(busy_ok), 1);
    chk({tag, " product"}, 32'(out_p), 32'(want));
    if (hold > 0) begin
      bit stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        in_a = 8'($urandom); in_b = 8'($urandom);
        @(negedge clk);
        if (!out_valid || out_p !== want || in_ready || !busy)
          stable = 1'b0;
      end
      in_valid = 1'b0;
      chk({tag, " stall stable"}, 32'(stable), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " release"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    #12;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_p", 32'(out_p), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h57, 8'h83, 0, "t1");
    run_op(8'h57, 8'h13, 0, "t2a");
    run_op(8'h02, 8'h80, 0, "t2b");
    run_op(8'h53, 8'hCA, 0, "t2c");
    run_op(8'h00, 8'hFF, 0, "t2d");
    run_op(8'hFF, 8'h01, 0, "t2e");
    run_op(8'h57, 8'h01, 0, "t6a");
    run_op(8'h57, 8'h00, 0, "zero_b");
    run_op(8'hC3, 8'h5A, 20, "t3");

    // Abort a calculation partway through
    @(negedge clk);
    in_a = 8'hAA; in_b = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t4 out_valid", 32'(out_valid), 0);
    chk("t4 in_ready", 32'(in_ready), 1);
    chk("t4 busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h57, 8'h83, 0, "t4 after");

    for (int k = 0; k < 300; k++)
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "rand");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
